// File: rtl/mem_pkg.sv
// Shared memory-port types, window defaults, and the pmem_read/pmem_write access functions.
// The functions are a self-contained sparse memory model, the single import point for all ports.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_e;

  localparam logic [63:0] MEM_BASE_DEFAULT = 64'h8000_0000;
  localparam logic [63:0] MEM_SIZE_DEFAULT = 64'h0800_0000;

  // Sparse backing store keyed by 64-bit word index; unwritten words read as zero.
  logic [63:0] pmem_mem [logic [63:0]];
  int unsigned pmem_rd_cnt;
  int unsigned pmem_wr_cnt;

  function automatic logic [63:0] pmem_peek(input logic [63:0] addr);
    logic [63:0] idx;
    idx = {3'b000, addr[63:3]};
    if (pmem_mem.exists(idx)) return pmem_mem[idx];
    return 64'h0;
  endfunction

  function automatic logic [63:0] pmem_read(input logic [63:0] addr);
    pmem_rd_cnt++;
    return pmem_peek(addr);
  endfunction

  function automatic void pmem_write(input logic [63:0] addr, input logic [63:0] wdata,
                                     input logic [7:0] wmask);
    logic [63:0] cur;
    cur = pmem_peek(addr);
    for (int i = 0; i < 8; i++) begin
      if (wmask[i]) cur[i*8 +: 8] = wdata[i*8 +: 8];
    end
    pmem_mem[{3'b000, addr[63:3]}] = cur;
    pmem_wr_cnt++;
  endfunction

endpackage

// File: rtl/mem_lane_sel.sv
// Steers a DATA_W-wide port onto the 64-bit pmem interface: read-lane select and
// write data/mask placement. Pure pass-through when DATA_W is 64.
module mem_lane_sel #(
  parameter int unsigned DATA_W = 64
) (
  input  logic                  lane,
  input  logic [63:0]           rd64,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wmask,
  output logic [DATA_W-1:0]     rdata,
  output logic [63:0]           wdata64,
  output logic [7:0]            wmask64
);

  if (DATA_W == 64) begin : g_pass
    logic unused_lane;
    assign unused_lane = lane;
    assign rdata       = rd64;
    assign wdata64     = wdata;
    assign wmask64     = wmask;
  end else begin : g_w32
    assign rdata   = lane ? rd64[63:32] : rd64[31:0];
    assign wdata64 = {wdata, wdata};
    assign wmask64 = lane ? {wmask, 4'b0000} : {4'b0000, wmask};
  end

endmodule

// File: rtl/dpi_mem_port.sv
// Handshaked memory port: latches one request, waits LATENCY cycles, performs a single
// pmem access and holds the registered response until the consumer accepts it.
module dpi_mem_port
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LATENCY = 1,
  parameter logic [63:0] BASE    = MEM_BASE_DEFAULT,
  parameter logic [63:0] SIZE    = MEM_SIZE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(MASK_W);
  localparam logic [63:0] LIMIT  = BASE + SIZE;

  mem_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [63:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [63:0]         rd64_q;
  logic                err_q;

  logic                access;
  logic                addr_err;
  logic [63:0]         dpi_addr;
  logic [63:0]         wdata64;
  logic [7:0]          wmask64;

  assign addr_err = (addr_q < BASE) || (addr_q >= LIMIT) || (addr_q[OFF_W-1:0] != '0);
  // 32-bit ports address the containing 64-bit word; the lane picks the half.
  assign dpi_addr = {addr_q[63:3], 3'b000};

  mem_lane_sel #(
    .DATA_W (DATA_W)
  ) u_lane_sel (
    .lane    (addr_q[2]),
    .rd64    (rd64_q),
    .wdata   (wdata_q),
    .wmask   (wmask_q),
    .rdata   (rsp_rdata),
    .wdata64 (wdata64),
    .wmask64 (wmask64)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 64'h0;
      wdata_q <= '0;
      wmask_q <= '0;
      rd64_q  <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= 64'(req_addr);
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        rd64_q  <= 64'h0;
        err_q   <= 1'b0;
      end
      // Single access point; rd64_q stays zero for writes and errors.
      if (access) begin
        err_q <= addr_err;
        if (!addr_err) begin
          if (we_q) begin
            if (wmask64 != 8'h00) pmem_write(dpi_addr, wdata64, wmask64);
          end else begin
            rd64_q <= pmem_read(dpi_addr);
          end
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

endmodule
